// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared state encoding, widths and helpers for the TDC sequencer
package tdc_pkg;

    localparam int CODE_W = 8;
    localparam int DROP_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        FREEZE = 3'd3,
        SCAN   = 3'd4,
        REPORT = 3'd5
    } state_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/tdc_thermo_scan.sv
// rtl/tdc_thermo_scan.sv - serial first-zero scanner over the frozen thermometer taps
module tdc_thermo_scan
    import tdc_pkg::*;
#(
    parameter int DELAY = 100
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic [DELAY-1:0]  i_tap,
    output logic              o_done,
    output logic [CODE_W-1:0] o_code,
    output logic              o_sat
);

    localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(DELAY - 1);

    logic              r_active;
    logic [CODE_W-1:0] r_idx;
    logic [255:0]      w_taps;
    logic              w_bit;

    // Padding to 256 lets the 8-bit index address the taps without range games.
    assign w_taps = 256'(i_tap);
    assign w_bit  = w_taps[r_idx];

    assign o_done = r_active && (!w_bit || (r_idx == LAST_IDX));
    assign o_code = r_idx;
    assign o_sat  = w_bit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active <= 1'b0;
            r_idx    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_idx    <= '0;
        end else if (o_done) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            r_idx <= r_idx + CODE_W'(1);
        end
    end

endmodule

// File: rtl/tdc_sequencer.sv
// rtl/tdc_sequencer.sv - TDC delay-line measurement sequencer with valid/ack result port
// Optional sample averaging is enabled by defining TDC_AVG_EN.
module tdc_sequencer
    import tdc_pkg::*;
#(
    parameter int DELAY     = 100,
    parameter int PERIOD    = 100000,
    parameter int CLEAR_CYC = 50,
    parameter int SETTLE    = 10
`ifdef TDC_AVG_EN
    ,
    parameter int AVG_LOG2  = 3
`endif
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              trig_req,
    input  logic [7:0]        freeze_dly,
    output logic              line_start,
    output logic              line_freeze,
    input  logic [DELAY-1:0]  line_tap,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ack,
    output logic [CODE_W-1:0] res_code,
    output logic              res_sat,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int PER_W = $clog2(PERIOD);
    localparam int CNT_W = 16;
    localparam logic [PER_W-1:0] PER_LAST    = PER_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    state_t            r_state;
    logic [PER_W-1:0]  r_per_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_fdly;
    logic              r_pending;
    logic              r_start;
    logic              r_freeze;
    logic              r_valid;
    logic [CODE_W-1:0] r_code;
    logic              r_sat;
    logic [DROP_W-1:0] r_drop;

    logic              w_auto;
    logic              w_launch;
    logic              w_busy;
    logic              w_scan_start;
    logic              w_done;
    logic [CODE_W-1:0] w_code;
    logic              w_sat;
    logic              w_last_sample;
    logic [CODE_W-1:0] w_res_code;
    logic              w_res_sat;

    assign w_auto       = enable && (r_per_cnt == PER_LAST);
    assign w_launch     = w_auto || trig_req || r_pending;
    assign w_busy       = (r_state != IDLE);
    assign w_scan_start = (r_state == FREEZE) && (r_cnt == SETTLE_LAST);

    assign line_start  = r_start;
    assign line_freeze = r_freeze;
    assign busy        = w_busy;
    assign res_valid   = r_valid;
    assign res_code    = r_code;
    assign res_sat     = r_sat;
    assign drop_cnt    = r_drop;

    tdc_thermo_scan #(
        .DELAY (DELAY)
    ) u_scan (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (w_scan_start),
        .i_tap   (line_tap),
        .o_done  (w_done),
        .o_code  (w_code),
        .o_sat   (w_sat)
    );

`ifdef TDC_AVG_EN
    localparam int SUM_W = CODE_W + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] SAMP_LAST = '1;

    logic [AVG_LOG2-1:0] r_sample;
    logic [SUM_W-1:0]    r_sum;
    logic                r_sat_acc;
    logic [SUM_W-1:0]    w_sum_next;
    logic                w_sat_next;

    assign w_sum_next    = r_sum + SUM_W'(w_code);
    assign w_sat_next    = r_sat_acc | w_sat;
    assign w_last_sample = (r_sample == SAMP_LAST);
    assign w_res_code    = w_sum_next[SUM_W-1:AVG_LOG2];
    assign w_res_sat     = w_sat_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sample  <= '0;
            r_sum     <= '0;
            r_sat_acc <= 1'b0;
        end else if ((r_state == SCAN) && w_done) begin
            if (w_last_sample) begin
                r_sample  <= '0;
                r_sum     <= '0;
                r_sat_acc <= 1'b0;
            end else begin
                r_sample  <= r_sample + AVG_LOG2'(1);
                r_sum     <= w_sum_next;
                r_sat_acc <= w_sat_next;
            end
        end
    end
`else
    assign w_last_sample = 1'b1;
    assign w_res_code    = w_code;
    assign w_res_sat     = w_sat;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_per_cnt <= '0;
        end else if (!enable || w_auto) begin
            r_per_cnt <= '0;
        end else begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
        end
    end

    // One-deep software request queue; auto requests are never queued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= 1'b0;
            r_drop    <= '0;
        end else begin
            if (!w_busy && w_launch) begin
                r_pending <= 1'b0;
            end else if (w_busy && trig_req) begin
                r_pending <= 1'b1;
            end
            if (w_busy && w_auto) begin
                r_drop <= sat_inc(r_drop);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_fdly   <= '0;
            r_start  <= 1'b0;
            r_freeze <= 1'b0;
            r_valid  <= 1'b0;
            r_code   <= '0;
            r_sat    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (r_cnt == CLEAR_LAST) begin
                        r_state <= LAUNCH;
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_fdly  <= freeze_dly;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                LAUNCH: begin
                    if (r_cnt == {8'd0, r_fdly}) begin
                        r_state  <= FREEZE;
                        r_cnt    <= '0;
                        r_freeze <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FREEZE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SCAN: begin
                    if (w_done) begin
                        if (w_last_sample) begin
                            r_state <= REPORT;
                            r_valid <= 1'b1;
                            r_code  <= w_res_code;
                            r_sat   <= w_res_sat;
                        end else begin
                            r_state  <= CLEAR;
                            r_cnt    <= '0;
                            r_start  <= 1'b0;
                            r_freeze <= 1'b0;
                        end
                    end
                end
                REPORT: begin
                    if (res_ack) begin
                        r_state  <= IDLE;
                        r_valid  <= 1'b0;
                        r_start  <= 1'b0;
                        r_freeze <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_sequencer.sv
// tb/tb_tdc_sequencer.sv - scoreboard bench for tdc_sequencer with a first-zero reference model
module tb_tdc_sequencer;

    localparam int DELAY     = 100;
    localparam int PERIOD    = 1000;
    localparam int CLEAR_CYC = 50;
    localparam int SETTLE    = 10;

    typedef struct {
        int code;
        bit sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             enable = 1'b0;
    logic             trig_req = 1'b0;
    logic [7:0]       freeze_dly = 8'd0;
    logic [DELAY-1:0] line_tap = '0;
    logic             res_ack = 1'b0;
    logic             line_start;
    logic             line_freeze;
    logic             busy;
    logic             res_valid;
    logic [7:0]       res_code;
    logic             res_sat;
    logic [7:0]       drop_cnt;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ack_mode = 0;
    int   t_trig = 0;
    int   t_start = 0;
    int   t_freeze = 0;
    int   t_valid = 0;
    int   n_results = 0;
    bit   rec_starts = 1'b0;
    bit   after_xfer = 1'b0;
    logic prev_start = 1'b0;
    logic prev_freeze = 1'b0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];
    int   start_times[$];

    tdc_sequencer #(
        .DELAY     (DELAY),
        .PERIOD    (PERIOD),
        .CLEAR_CYC (CLEAR_CYC),
        .SETTLE    (SETTLE)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .trig_req    (trig_req),
        .freeze_dly  (freeze_dly),
        .line_start  (line_start),
        .line_freeze (line_freeze),
        .line_tap    (line_tap),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ack     (res_ack),
        .res_code    (res_code),
        .res_sat     (res_sat),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [DELAY-1:0] taps);
        exp_t e;
        e.code = DELAY - 1;
        e.sat  = 1'b1;
        for (int i = 0; i < DELAY; i++) begin
            if (!taps[i]) begin
                e.code = i;
                e.sat  = 1'b0;
                break;
            end
        end
        return e;
    endfunction

    function automatic logic [DELAY-1:0] make_taps(input int k, input bit bubbles);
        logic [DELAY-1:0] t;
        t = '0;
        for (int i = 0; i < k && i < DELAY; i++) t[i] = 1'b1;
        if (bubbles) for (int i = k + 1; i < DELAY; i++) t[i] = 1'($urandom_range(0, 1));
        return t;
    endfunction

    function automatic int latency(input int fd, input int code);
        return CLEAR_CYC + fd + 1 + SETTLE + code + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trig();
        trig_req = 1'b1;
        t_trig   = cyc + 1;
        step();
        trig_req = 1'b0;
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n = 0;
        while (!res_valid && n < limit) begin
            step();
            n++;
        end
        check(name, int'(n < limit), 1);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || res_valid) && n < limit) begin
            step();
            n++;
        end
        check(name, int'(n < limit), 1);
    endtask

    task automatic pulse_reset();
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async_start", line_start, 0);
        check("rst_async_freeze", line_freeze, 0);
        check("rst_async_valid", res_valid, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_code", res_code, 0);
        step();
        rstn = 1'b1;
        step();
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (ack_mode)
            0:       res_ack = 1'b0;
            1:       res_ack = 1'b1;
            default: res_ack = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Monitor: edge timestamps, result scoreboard and handshake invariants.
    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (after_xfer) begin
                check("valid_fall_after_ack", res_valid, 0);
                check("busy_after_ack", busy, 0);
                after_xfer = 1'b0;
            end
            check("freeze_not_before_start", int'(line_freeze & ~line_start), 0);
            if (line_start && !prev_start) begin
                t_start = cyc;
                if (rec_starts) start_times.push_back(cyc);
            end
            if (line_freeze && !prev_freeze) t_freeze = cyc;
            if (res_valid && !prev_valid) t_valid = cyc;
            if (res_valid && res_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=code %0d required=no result", res_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_code", res_code, e.code);
                    check("res_sat", res_sat, e.sat);
                end
                n_results++;
                after_xfer = 1'b1;
            end
        end
        prev_start  = line_start;
        prev_freeze = line_freeze;
        prev_valid  = res_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        exp_t e;

        repeat (3) step();
        check("reset_line_start", line_start, 0);
        check("reset_line_freeze", line_freeze, 0);
        check("reset_busy", busy, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_code", res_code, 0);
        check("reset_res_sat", res_sat, 0);
        check("reset_drop_cnt", drop_cnt, 0);
        rstn = 1'b1;
        step();

        // Single trigger, first zero at tap 37, result held until acked.
        line_tap   = make_taps(37, 1'b0);
        freeze_dly = 8'd0;
        ack_mode   = 0;
        exp_q.push_back(model(line_tap));
        trig();
        wait_valid(400, "t1_valid_timeout");
        repeat (5) step();
        check("t1_valid_held", res_valid, 1);
        check("t1_latency", t_valid - t_trig, latency(0, 37));
        check("t1_freeze_gap", t_freeze - t_start, 1);
        ack_mode = 1;
        wait_idle(50, "t1_idle_timeout");
        check("t1_drop_cnt", drop_cnt, 0);

        // Saturated scan: all taps high.
        line_tap = '1;
        exp_q.push_back(model(line_tap));
        trig();
        wait_idle(400, "t2_idle_timeout");
        check("t2_latency", t_valid - t_trig, latency(0, DELAY - 1));
        check("t2_scan_latency", t_valid - t_freeze, SETTLE + DELAY);

        // Auto mode with ack tied high: three launches one period apart.
        line_tap = make_taps(20, 1'b1);
        start_times.delete();
        rec_starts = 1'b1;
        repeat (3) exp_q.push_back(model(line_tap));
        enable = 1'b1;
        repeat (3 * PERIOD + 500) step();
        enable = 1'b0;
        wait_idle(500, "t3_idle_timeout");
        rec_starts = 1'b0;
        check("t3_launch_count", start_times.size(), 3);
        for (int i = 1; i < start_times.size(); i++)
            check("t3_launch_spacing", start_times[i] - start_times[i-1], PERIOD);
        check("t3_drop_cnt", drop_cnt, 0);

        // Auto mode with result left pending: later auto requests are dropped.
        ack_mode = 0;
        line_tap = make_taps(64, 1'b0);
        exp_q.push_back(model(line_tap));
        enable = 1'b1;
        repeat (3 * PERIOD + 200) step();
        enable = 1'b0;
        check("t4_drop_cnt", drop_cnt, 2);
        ack_mode = 1;
        wait_idle(500, "t4_idle_timeout");

        // Back-to-back triggers: second is held pending, third is lost.
        ack_mode = 2;
        line_tap = make_taps(7, 1'b1);
        n0 = n_results;
        repeat (2) exp_q.push_back(model(line_tap));
        trig();
        repeat (4) step();
        trig();
        repeat (4) step();
        trig();
        wait_idle(2000, "t5_idle_timeout");
        repeat (300) step();
        check("t5_result_count", n_results - n0, 2);
        check("t5_busy_after", busy, 0);

        // Reset during SCAN.
        ack_mode = 0;
        line_tap = '1;
        trig();
        n = 0;
        while (!line_freeze && n < 300) begin
            step();
            n++;
        end
        check("t6_freeze_seen", int'(n < 300), 1);
        repeat (SETTLE + 30) step();
        pulse_reset();

        // Reset while a result is held.
        line_tap = make_taps(3, 1'b0);
        trig();
        wait_valid(400, "t6b_valid_timeout");
        pulse_reset();
        check("t6_drop_after_reset", drop_cnt, 0);

        // Clean measurement after reset.
        ack_mode = 1;
        line_tap = make_taps(5, 1'b0);
        exp_q.push_back(model(line_tap));
        trig();
        wait_idle(400, "t6_clean_timeout");
        check("t6_clean_latency", t_valid - t_trig, latency(0, 5));

        // Randomized measurements.
        for (int it = 0; it < 20; it++) begin
            line_tap   = make_taps($urandom_range(0, DELAY), 1'($urandom_range(0, 1)));
            freeze_dly = 8'($urandom_range(0, 15));
            ack_mode   = $urandom_range(1, 2);
            e = model(line_tap);
            exp_q.push_back(e);
            trig();
            wait_idle(2000, "rand_idle_timeout");
        end

        repeat (5) step();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_busy", busy, 0);
        check("final_drop_cnt", drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
